text_console_writer: RTL and testbench

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer.sv | 121 ++++++++++++
 tb/tb_text_console_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Character console writer: turns a char/attr stream into VRAM word writes,
// tracks a wrapping cursor and blanks the screen after reset or on request.
module text_console_writer #(
    parameter int          COLS         = 60,
    parameter int          ROWS         = 34,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h07
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  char_i,
    input  logic [7:0]  attr_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        clear_i,
    output logic        vram_cea_o,
    output logic [10:0] vram_ada_o,
    output logic [15:0] vram_din_o,
    output logic        busy_o,
    output logic [5:0]  cursor_col_o,
    output logic [5:0]  cursor_row_o
);

    // state  | meaning
    // IDLE   | accepting characters, one per cycle
    // CLEAR  | writing blank words to every cell, ascending
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [10:0] LAST_ADDR = 11'(COLS * ROWS - 1);
    localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
    localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    logic [0:0]  state;
    logic        init_pending;
    logic        accept;
    logic        printable;
    logic        start_clear;
    logic [10:0] cur_addr;
    logic [5:0]  row_inc;

    // init_pending forces the post-reset blanking on the first edge after release
    assign ready_o     = rst_n_i && (state == ST_IDLE) && !init_pending && !clear_i;
    assign busy_o      = (state == ST_CLEAR);
    assign accept      = valid_i && ready_o;
    assign printable   = (char_i >= 8'h20);
    assign start_clear = (state == ST_IDLE) &&
                         (init_pending || clear_i || (accept && char_i == CH_FF));
    assign cur_addr    = 11'(cursor_row_o) * 11'(COLS) + 11'(cursor_col_o);
    assign row_inc     = (cursor_row_o == LAST_ROW) ? 6'd0 : cursor_row_o + 6'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            init_pending <= 1'b1;
            vram_cea_o   <= 1'b0;
            vram_ada_o   <= 11'd0;
            vram_din_o   <= 16'd0;
            cursor_col_o <= 6'd0;
            cursor_row_o <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_clear) begin
                        // first blank word goes out on the entry edge itself
                        state        <= ST_CLEAR;
                        init_pending <= 1'b0;
                        vram_cea_o   <= 1'b1;
                        vram_ada_o   <= 11'd0;
                        vram_din_o   <= {DEFAULT_ATTR, 8'h20};
                        cursor_col_o <= 6'd0;
                        cursor_row_o <= 6'd0;
                    end else begin
                        vram_cea_o <= 1'b0;
                        if (accept) begin
                            if (printable) begin
                                vram_cea_o <= 1'b1;
                                vram_ada_o <= cur_addr;
                                vram_din_o <= {attr_i, char_i};
                                if (cursor_col_o == LAST_COL) begin
                                    cursor_col_o <= 6'd0;
                                    cursor_row_o <= row_inc;
                                end else begin
                                    cursor_col_o <= cursor_col_o + 6'd1;
                                end
                            end else begin
                                case (char_i)
                                    CH_LF: begin
                                        cursor_col_o <= 6'd0;
                                        cursor_row_o <= row_inc;
                                    end
                                    CH_CR: cursor_col_o <= 6'd0;
                                    CH_BS: begin
                                        if (cursor_col_o != 6'd0)
                                            cursor_col_o <= cursor_col_o - 6'd1;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    if (vram_ada_o == LAST_ADDR) begin
                        state      <= ST_IDLE;
                        vram_cea_o <= 1'b0;
                    end else begin
                        vram_cea_o <= 1'b1;
                        vram_ada_o <= vram_ada_o + 11'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: expected VRAM writes are queued by
// the stimulus and popped by an independent monitor on every write strobe.
module tb_text_console_writer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  char_i;
    logic [7:0]  attr_i;
    logic        valid_i;
    logic        ready_o;
    logic        clear_i;
    logic        vram_cea_o;
    logic [10:0] vram_ada_o;
    logic [15:0] vram_din_o;
    logic        busy_o;
    logic [5:0]  cursor_col_o;
    logic [5:0]  cursor_row_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = 0;

    logic [26:0] exp_q[$];

    text_console_writer #(.COLS(60), .ROWS(34), .DEFAULT_ATTR(8'h07)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .char_i       (char_i),
        .attr_i       (attr_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .clear_i      (clear_i),
        .vram_cea_o   (vram_cea_o),
        .vram_ada_o   (vram_ada_o),
        .vram_din_o   (vram_din_o),
        .busy_o       (busy_o),
        .cursor_col_o (cursor_col_o),
        .cursor_row_o (cursor_row_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_cursor(input string name, input int col, input int row);
        chk(name, {26'd0, cursor_col_o}, 32'(col));
        chk(name, {26'd0, cursor_row_o}, 32'(row));
    endtask

    task automatic push_clear(input int count);
        for (int i = 0; i < count; i++) exp_q.push_back({11'(i), 16'h0720});
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        char_i  = c;
        attr_i  = a;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_o === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_empty(input string name);
        #2;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    initial begin
        logic [26:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (vram_cea_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%h, no write expected",
                             vram_ada_o, vram_din_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("vram_write", {5'd0, vram_ada_o, vram_din_o}, {5'd0, e});
                end
                prev_wr_cyc = last_wr_cyc;
                last_wr_cyc = cyc;
            end
        end
    end

    initial begin
        int n;
        bit found;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        char_i  = 8'h00;
        attr_i  = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_cea",   {31'd0, vram_cea_o}, 32'd0);
        chk("rst_ada",   {21'd0, vram_ada_o}, 32'd0);
        chk("rst_din",   {16'd0, vram_din_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk_cursor("rst_cursor", 0, 0);

        // Reset release blanks the whole screen
        push_clear(2040);
        rst_n = 1'b1;
        @(negedge clk);
        chk("clr_busy_entry", {31'd0, busy_o}, 32'd1);
        count_busy(n);
        chk("reset_clear_len", 32'(n), 32'd2040);
        chk("post_clear_ready", {31'd0, ready_o}, 32'd1);
        chk_cursor("post_clear_cursor", 0, 0);
        check_empty("reset_clear_writes");

        // Back-to-back "AB"
        exp_q.push_back({11'd0, 16'h1E41});
        exp_q.push_back({11'd1, 16'h1E42});
        send(8'h41, 8'h1E);
        send(8'h42, 8'h1E);
        @(negedge clk);
        check_empty("ab_writes");
        chk("ab_back_to_back", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);
        chk_cursor("ab_cursor", 2, 0);

        // Move to (59,33), then wrap
        for (int i = 0; i < 33; i++) send(8'h0A, 8'h07);
        chk_cursor("lf33_cursor", 0, 33);
        for (int i = 0; i < 59; i++) begin
            exp_q.push_back({11'(1980 + i), 16'h0720});
            send(8'h20, 8'h07);
        end
        chk_cursor("last_cell_cursor", 59, 33);
        exp_q.push_back({11'd2039, 16'h0758});
        send(8'h58, 8'h07);
        chk_cursor("wrap_cursor", 0, 0);
        send(8'h0A, 8'h07);
        chk_cursor("lf_after_wrap", 0, 1);
        check_empty("wrap_writes");

        // BS / CR / ignored control at (5,3)
        send(8'h0A, 8'h07);
        send(8'h0A, 8'h07);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({11'(180 + i), 16'(16'h0730 + i)});
            send(8'(8'h30 + i), 8'h07);
        end
        chk_cursor("pos_5_3", 5, 3);
        send(8'h08, 8'h07);
        chk_cursor("bs_cursor", 4, 3);
        send(8'h0D, 8'h07);
        chk_cursor("cr_cursor", 0, 3);
        send(8'h08, 8'h07);
        chk_cursor("bs_at_col0", 0, 3);
        send(8'h01, 8'h07);
        chk_cursor("ignored_ctrl", 0, 3);
        check_empty("ctrl_no_writes");

        // clear_i wins over valid_i
        push_clear(2040);
        clear_i = 1'b1;
        valid_i = 1'b1;
        char_i  = 8'h5A;
        attr_i  = 8'h07;
        #1;
        chk("ready_during_clear_req", {31'd0, ready_o}, 32'd0);
        @(negedge clk);
        clear_i = 1'b0;
        valid_i = 1'b0;
        chk("clear_req_busy", {31'd0, busy_o}, 32'd1);
        chk_cursor("clear_req_cursor", 0, 0);
        count_busy(n);
        chk("clear_req_len", 32'(n), 32'd2040);
        check_empty("clear_req_writes");

        // Form feed behaves like clear_i
        exp_q.push_back({11'd0, 16'h0751});
        send(8'h51, 8'h07);
        chk_cursor("pre_ff_cursor", 1, 0);
        push_clear(2040);
        send(8'h0C, 8'h07);
        chk("ff_busy", {31'd0, busy_o}, 32'd1);
        chk_cursor("ff_cursor", 0, 0);
        count_busy(n);
        chk("ff_clear_len", 32'(n), 32'd2040);
        chk("ff_ready_after", {31'd0, ready_o}, 32'd1);
        check_empty("ff_writes");

        // Reset in the middle of a clear
        push_clear(1001);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (vram_cea_o === 1'b1 && vram_ada_o == 11'd1000) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_addr_1000", {31'd0, found}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midclr_rst_cea",   {31'd0, vram_cea_o}, 32'd0);
        chk("midclr_rst_ada",   {21'd0, vram_ada_o}, 32'd0);
        chk("midclr_rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("midclr_rst_ready", {31'd0, ready_o}, 32'd0);
        check_empty("midclr_writes");
        exp_q.delete();
        push_clear(2040);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_busy", {31'd0, busy_o}, 32'd1);
        count_busy(n);
        chk("restart_len", 32'(n), 32'd2040);
        check_empty("restart_writes");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
